// File: rtl/prog_clock_divider.sv
// Programmable clock divider: registered clk_out with period div_cur, glitch-free divisor updates at period boundaries.
// Optional macro CLKDIV_TICK_EN enables the tick pulse register; otherwise tick is tied low.
module prog_clock_divider #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic [WIDTH-1:0] div_cur,
  output logic             running,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO_W       = WIDTH'(2);
  localparam logic [WIDTH-1:0] RESET_DIV_W = WIDTH'(RESET_DIV);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_cur;
  logic [WIDTH-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_clk_out;
  logic             r_ack;
  logic             r_err;

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_boundary;
  logic             w_load_ok;
  logic             w_apply;

  assign w_hi       = r_div_cur >> 1;
  assign w_last     = r_div_cur - ONE_W;
  assign w_cnt_inc  = r_cnt + ONE_W;
  assign w_boundary = (r_state == S_RUN) && (r_cnt == w_last);
  assign w_load_ok  = div_load && (div_in >= TWO_W);
  // Pending divisor only takes effect where no period is in progress.
  assign w_apply    = r_pend_vld && ((r_state == S_IDLE) || w_boundary);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div_cur  <= RESET_DIV_W;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_clk_out  <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ack <= w_load_ok;
      r_err <= div_load && !w_load_ok;

      if (w_apply) begin
        r_div_cur <= r_pend;
      end
      // A load on the apply edge survives as the next pending value.
      if (w_load_ok) begin
        r_pend     <= div_in;
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (en) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (!w_boundary) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == w_hi) begin
              r_clk_out <= 1'b0;
            end
          end else if (en) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b1;
          end else begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CLKDIV_TICK_EN
  logic r_tick;
  logic w_start;

  // Every edge that drives clk_out high starts a period and emits a tick.
  assign w_start = en && ((r_state == S_IDLE) || w_boundary);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_start;
    end
  end

  assign tick = r_tick;
`else
  assign tick = 1'b0;
`endif

  assign div_ack = r_ack;
  assign div_err = r_err;
  assign div_cur = r_div_cur;
  assign running = (r_state == S_RUN);
  assign clk_out = r_clk_out;

endmodule
